// File: rtl/msrv32_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : msrv32_pipe_ctrl
// Purpose  : Sequencing controller for the msrv32 stage-2 pipeline register.
//            Each cycle it decides whether stage 2 captures new decode
//            results, holds them during a data-memory wait, or loads a bubble
//            after a branch/trap/mret redirect. It also selects the next-PC
//            source and gates instruction fetch.
// Ports    : clk_in            core clock, rising edge
//            reset_in          asynchronous active-high reset
//            trap_taken_in     exception/interrupt accepted this cycle
//            mret_in           mret retiring this cycle
//            branch_taken_in   branch/jump resolved taken this cycle
//            dmem_req_in       stage-2 instruction issues a load/store
//            dmem_ack_in       data memory completes the access this cycle
//            reg2_load_out     stage-2 register captures (0 = hold)
//            reg2_flush_out    stage-2 register loads a bubble
//            pc_sel_out        00 boot, 01 pc+4, 10 iadder, 11 CSR vector
//            imem_req_out      fetch enable
//            bus_err_out       one-cycle data-bus timeout pulse
//            stall_cycles_out  saturating wait-cycle count since reset
// Config   : MSRV32_DMEM_TIMEOUT_EN  enables the data-bus wait timeout.
//            Without it a wait lasts until ack and bus_err_out is 0.
// Revision : 1.0  initial release
// ============================================================================
module msrv32_pipe_ctrl #(
  parameter int STALL_CNT_W    = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        trap_taken_in,
  input  logic        mret_in,
  input  logic        branch_taken_in,
  input  logic        dmem_req_in,
  input  logic        dmem_ack_in,
  output logic        reg2_load_out,
  output logic        reg2_flush_out,
  output logic [1:0]  pc_sel_out,
  output logic        imem_req_out,
  output logic        bus_err_out,
  output logic [31:0] stall_cycles_out
);

  localparam logic [1:0] PC_BOOT = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_ADDR = 2'b10;
  localparam logic [1:0] PC_CSR  = 2'b11;

  // The timeout compare value must fit in the wait counter.
  if (TIMEOUT_CYCLES >= (1 << STALL_CNT_W) || TIMEOUT_CYCLES < 1) begin : g_timeout_range_err
    $error("msrv32_pipe_ctrl: TIMEOUT_CYCLES out of range for STALL_CNT_W");
  end

  typedef enum logic [1:0] {
    RESET_S = 2'd0,
    RUN_S   = 2'd1,
    WAIT_S  = 2'd2,
    FLUSH_S = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [STALL_CNT_W-1:0] wait_cnt;
  logic [STALL_CNT_W-1:0] wait_cnt_nxt;
  logic [31:0]            stall_nxt;

`ifdef MSRV32_DMEM_TIMEOUT_EN
  localparam logic [STALL_CNT_W-1:0] TIMEOUT_LAST = STALL_CNT_W'(TIMEOUT_CYCLES - 1);
  logic timeout_hit;
`endif

  // --------------------------------------------------------------------------
  // State, wait counter and stall counter registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state            <= RESET_S;
      wait_cnt         <= '0;
      stall_cycles_out <= '0;
    end else begin
      state            <= state_nxt;
      wait_cnt         <= wait_cnt_nxt;
      stall_cycles_out <= stall_nxt;
    end
  end

`ifdef MSRV32_DMEM_TIMEOUT_EN
  // Pulse is registered: it appears in the FLUSH_S cycle after the timeout.
  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      bus_err_out <= 1'b0;
    end else begin
      bus_err_out <= timeout_hit;
    end
  end
`else
  assign bus_err_out = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    stall_nxt      = stall_cycles_out;
    reg2_load_out  = 1'b1;
    reg2_flush_out = 1'b0;
    pc_sel_out     = PC_INC;
    imem_req_out   = 1'b1;
`ifdef MSRV32_DMEM_TIMEOUT_EN
    timeout_hit    = 1'b0;
`endif

    case (state)
      RESET_S: begin
        reg2_flush_out = 1'b1;
        pc_sel_out     = PC_BOOT;
        state_nxt      = RUN_S;
      end

      RUN_S: begin
        // Redirects beat a pending stall; a stall beats a taken branch
        // because the branch instruction itself must wait for memory.
        if (trap_taken_in || mret_in) begin
          pc_sel_out     = PC_CSR;
          reg2_flush_out = 1'b1;
          state_nxt      = FLUSH_S;
        end else if (dmem_req_in && !dmem_ack_in) begin
          reg2_load_out  = 1'b0;
          imem_req_out   = 1'b0;
          wait_cnt_nxt   = '0;
          state_nxt      = WAIT_S;
        end else if (branch_taken_in) begin
          pc_sel_out     = PC_ADDR;
          reg2_flush_out = 1'b1;
          state_nxt      = FLUSH_S;
        end
      end

      WAIT_S: begin
        reg2_load_out = 1'b0;
        imem_req_out  = 1'b0;
        if (dmem_ack_in) begin
          // The ack cycle releases the hold and is not counted as a stall.
          reg2_load_out = 1'b1;
          state_nxt     = RUN_S;
        end else begin
          if (stall_cycles_out != 32'hFFFF_FFFF) begin
            stall_nxt = stall_cycles_out + 32'd1;
          end
          if (wait_cnt != {STALL_CNT_W{1'b1}}) begin
            wait_cnt_nxt = wait_cnt + 1'b1;
          end
`ifdef MSRV32_DMEM_TIMEOUT_EN
          // Abandon the access and vector to the trap handler; any late ack
          // lands in FLUSH_S/RUN_S where it has no effect.
          if (wait_cnt == TIMEOUT_LAST) begin
            timeout_hit    = 1'b1;
            pc_sel_out     = PC_CSR;
            reg2_flush_out = 1'b1;
            reg2_load_out  = 1'b1;
            state_nxt      = FLUSH_S;
          end
`endif
        end
      end

      FLUSH_S: begin
        // Single bubble; redirect requests are ignored here and the CSR file
        // keeps interrupts pending until RUN_S accepts them.
        reg2_flush_out = 1'b1;
        state_nxt      = RUN_S;
      end

      default: begin
        state_nxt = RESET_S;
      end
    endcase

    // Asynchronous reset forces a safe output pattern immediately.
    if (reset_in) begin
      reg2_load_out  = 1'b0;
      reg2_flush_out = 1'b1;
      pc_sel_out     = PC_BOOT;
      imem_req_out   = 1'b0;
    end
  end

endmodule
`default_nettype wire
